// File: rtl/cmd_sequencer_if.sv
// rtl/cmd_sequencer_if.sv - command, scan and reply signal bundle for cmd_sequencer
interface cmd_sequencer_if #(
  parameter int NUM_CH = 4
);
  localparam int CW = $clog2(NUM_CH);

  // Command input from the UART receiver
  logic          rx_valid;
  logic [7:0]    rx_data;

  // Datapath status
  logic [7:0]    max_value;
  logic          fft_ready;
  logic          trigger;

  // Reply handshake toward the UART transmitter
  logic          tx_ready;
  logic          tx_valid;
  logic [7:0]    tx_data;

  // Datapath control and visibility
  logic [CW-1:0] rd_ch;
  logic          set_freq;
  logic          set_thresh;
  logic          busy;
  logic [2:0]    state_debug;

  // Environment side: drives commands and status, observes control and replies
  modport master (
    output rx_valid, rx_data, max_value, fft_ready, trigger, tx_ready,
    input  rd_ch, set_freq, set_thresh, tx_valid, tx_data, busy, state_debug
  );

  // Sequencer side
  modport slave (
    input  rx_valid, rx_data, max_value, fft_ready, trigger, tx_ready,
    output rd_ch, set_freq, set_thresh, tx_valid, tx_data, busy, state_debug
  );
endinterface

// File: rtl/cmd_sequencer.sv
// rtl/cmd_sequencer.sv - byte command decoder, trigger scan sequencer and reply generator
module cmd_sequencer #(
  parameter int         NUM_CH      = 4,
  parameter int         TIMEOUT_CYC = 10000000,
  parameter logic [7:0] TRUE_BYTE   = 8'h54,
  parameter logic [7:0] FALSE_BYTE  = 8'h46
) (
  input  logic           clk,
  input  logic           reset_b,
  cmd_sequencer_if.slave bus
);
  localparam int CW = $clog2(NUM_CH);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CH_LAST    = CW'(NUM_CH - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    DETECT = 3'd2,
    SCAN   = 3'd3,
    SEND   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    cmd_hi, cmd_hi_nxt;        // only the opcode nibble matters
  logic [TW-1:0] timer, timer_nxt;          // one count per detect session
  logic [CW-1:0] ch_idx, ch_idx_nxt;
  logic [7:0]    tx_byte, tx_byte_nxt;      // byte currently presented
  logic [7:0]    byte1, byte1_nxt;          // second reply byte (channel)
  logic          byte1_pend, byte1_pend_nxt;

  logic          abort;
  logic          timeout;
  logic          set_freq_c;
  logic          set_thresh_c;
  logic          tx_valid_c;
  logic          busy_c;
  logic [CW-1:0] rd_ch_c;

  // A zero byte is the host's way of cancelling a detect session
  assign abort   = bus.rx_valid && (bus.rx_data == 8'h00);
  assign timeout = (timer == TIMER_LAST);

  // Next-state and output decode; timeout outranks trigger and fft_ready
  always_comb begin
    state_nxt      = state;
    cmd_hi_nxt     = cmd_hi;
    timer_nxt      = timer;
    ch_idx_nxt     = ch_idx;
    tx_byte_nxt    = tx_byte;
    byte1_nxt      = byte1;
    byte1_pend_nxt = byte1_pend;
    set_freq_c     = 1'b0;
    set_thresh_c   = 1'b0;
    tx_valid_c     = 1'b0;
    busy_c         = 1'b0;
    rd_ch_c        = '0;

    case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          cmd_hi_nxt = bus.rx_data[7:4];
          state_nxt  = DECODE;
        end
      end

      DECODE: begin
        busy_c    = 1'b1;
        state_nxt = IDLE;
        if (cmd_hi[3]) begin
          set_thresh_c = 1'b1;
        end else begin
          case (cmd_hi)
            4'h7: set_freq_c = 1'b1;
            4'h4: begin
              tx_byte_nxt    = bus.max_value;
              byte1_pend_nxt = 1'b0;
              state_nxt      = SEND;
            end
            4'h5: begin
              timer_nxt  = '0;
              ch_idx_nxt = '0;
              state_nxt  = DETECT;
            end
            default: state_nxt = IDLE;
          endcase
        end
      end

      DETECT: begin
        busy_c    = 1'b1;
        timer_nxt = timer + TW'(1);
        if (abort) begin
          state_nxt = IDLE;
        end else if (timeout) begin
          tx_byte_nxt    = FALSE_BYTE;
          byte1_pend_nxt = 1'b0;
          state_nxt      = SEND;
        end else if (bus.fft_ready) begin
          ch_idx_nxt = '0;
          state_nxt  = SCAN;
        end
      end

      SCAN: begin
        busy_c    = 1'b1;
        rd_ch_c   = ch_idx;
        timer_nxt = timer + TW'(1);
        if (abort) begin
          state_nxt = IDLE;
        end else if (timeout) begin
          tx_byte_nxt    = FALSE_BYTE;
          byte1_pend_nxt = 1'b0;
          state_nxt      = SEND;
        end else if (bus.trigger) begin
          tx_byte_nxt    = TRUE_BYTE;
          byte1_nxt      = 8'(ch_idx);
          byte1_pend_nxt = 1'b1;
          state_nxt      = SEND;
        end else if (ch_idx == CH_LAST) begin
          ch_idx_nxt = '0;
          state_nxt  = DETECT;
        end else begin
          ch_idx_nxt = ch_idx + CW'(1);
        end
      end

      SEND: begin
        busy_c     = 1'b1;
        tx_valid_c = 1'b1;
        if (bus.tx_ready) begin
          if (byte1_pend) begin
            tx_byte_nxt    = byte1;
            byte1_pend_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command, timer, channel and reply registers; reset discards any reply in flight
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      cmd_hi     <= '0;
      timer      <= '0;
      ch_idx     <= '0;
      tx_byte    <= '0;
      byte1      <= '0;
      byte1_pend <= 1'b0;
    end else begin
      cmd_hi     <= cmd_hi_nxt;
      timer      <= timer_nxt;
      ch_idx     <= ch_idx_nxt;
      tx_byte    <= tx_byte_nxt;
      byte1      <= byte1_nxt;
      byte1_pend <= byte1_pend_nxt;
    end
  end

  assign bus.rd_ch       = rd_ch_c;
  assign bus.set_freq    = set_freq_c;
  assign bus.set_thresh  = set_thresh_c;
  assign bus.tx_valid    = tx_valid_c;
  assign bus.tx_data     = tx_valid_c ? tx_byte : 8'h00;
  assign bus.busy        = busy_c;
  assign bus.state_debug = state;
endmodule

// File: doc/cmd_sequencer.md
CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4, number of hydrophone channels scanned per FFT frame (2..16).
REQ-002 Parameter TIMEOUT_CYC, default 10000000, clk cycles allowed in detect mode before a FALSE reply (>=2).
REQ-003 Parameter TRUE_BYTE, default 8'h54, reply byte for trigger detected.
REQ-004 Parameter FALSE_BYTE, default 8'h46, reply byte for timeout.
REQ-005 clk  in  1  single clock; every flop is on its rising edge.
REQ-006 reset_b  in  1  synchronous, active-low reset.
REQ-007 rx_valid  in  1  one-cycle strobe: rx_data holds a received command byte.
REQ-008 rx_data  in  8  command byte.
REQ-009 max_value  in  8  current peak magnitude, sent on request.
REQ-010 fft_ready  in  1  new FFT frame available for scanning.
REQ-011 trigger  in  1  threshold comparison result for channel rd_ch, valid in the same cycle.
REQ-012 tx_ready  in  1  UART transmitter accepts tx_data when tx_valid=1.
REQ-013 rd_ch  out  $clog2(NUM_CH)  channel select for the RAM/threshold datapath.
REQ-014 set_freq / set_thresh  out  1 each  one-cycle load strobes for the frequency/threshold registers.
REQ-015 tx_valid / tx_data  out  1 / 8  transmit handshake and byte.
REQ-016 busy / state_debug  out  1 / 3  high when state!=IDLE; current state encoding.

Function
REQ-017 States: IDLE=0, DECODE=1, DETECT=2, SCAN=3, SEND=4; all other encodings SHALL go to IDLE with all outputs inactive.
REQ-018 IDLE: rx_valid=1 latches rx_data into cmd and moves to DECODE next cycle; otherwise stay.
REQ-019 DECODE (exactly 1 cycle), on cmd[7:4]: 0x7 -> set_freq=1, to IDLE; 0x8-0xF -> set_thresh=1, to IDLE; 0x4 -> load byte0=max_value (sampled this cycle), single byte, to SEND; 0x5 -> clear timer and channel index, to DETECT; any other -> IDLE, no reply.
REQ-020 set_freq/set_thresh SHALL be high only in the DECODE cycle and never simultaneously.
REQ-021 DETECT: timer increments each cycle; fft_ready=1 -> SCAN with channel index 0.
REQ-022 SCAN: rd_ch=channel index; trigger=1 -> load byte0=TRUE_BYTE, byte1={zero-extended channel index}, two-byte reply, to SEND; else if index==NUM_CH-1 -> DETECT; else index+1, stay in SCAN. One channel per cycle; NUM_CH cycles per full scan.
REQ-023 Timer also increments in SCAN; timer never resets inside one detect session.
REQ-024 Timeout: timer==TIMEOUT_CYC-1 in DETECT or SCAN -> load byte0=FALSE_BYTE, single byte, to SEND; timeout SHALL take priority over trigger and fft_ready in the same cycle.
REQ-025 Abort: rx_valid=1 with rx_data==8'h00 in DETECT or SCAN -> IDLE next cycle, no reply; any other rx_valid outside IDLE is dropped.
REQ-026 SEND: tx_valid=1, tx_data=current byte; on tx_valid&tx_ready: if byte1 pending, present byte1 next cycle and stay; else to IDLE. tx_data SHALL be stable while tx_valid=1 and tx_ready=0.
REQ-027 rd_ch SHALL be 0 outside SCAN; tx_valid SHALL be 0 outside SEND.
REQ-028 Reply latency: command 0x4x with tx_ready=1 -> tx_valid high 2 cycles after the rx_valid cycle.

Reset
REQ-029 reset_b=0 sampled at a clk edge SHALL force IDLE, timer=0, channel index=0, pending byte cleared, and all outputs 0 (state_debug=0) on the next cycle, including mid-SCAN or mid-SEND; a reply in progress is discarded.

Verification
REQ-030 rx 0x72 -> set_freq=1 for exactly one cycle 1 cycle later, no tx_valid; rx 0xA5 -> set_thresh one-cycle pulse.
REQ-031 max_value=0x3C, rx 0x40, tx_ready=1 -> tx_valid one cycle with tx_data=0x3C, then IDLE.
REQ-032 NUM_CH=4, rx 0x50, fft_ready, trigger high only when rd_ch=2 -> rd_ch sequence 0,1,2, then bytes 0x54, 0x02; tx_ready held low 5 cycles -> tx_data held.
REQ-033 TIMEOUT_CYC=20, rx 0x50, no trigger -> single 0x46 with tx_valid rising 20 cycles after DETECT entry; trigger and timeout in same cycle -> 0x46 only.
REQ-034 rx 0x50 then rx 0x00 -> IDLE, busy=0, no reply; rx 0x13 in IDLE -> no strobe, no reply.
REQ-035 reset_b low for 1 cycle during SCAN and during byte1 of SEND -> all outputs 0, state_debug=0, next rx 0x40 handled normally.
